multicycle_main_control: RTL
============================

// Module: multicycle_main_control
// PURPOSE
//  Multi-cycle main control FSM for the RISC-V core. It decodes the IR opcode, sequences
//  fetch, decode, execute, memory and writeback, and drives the datapath mux/enable strobes.
//  It is the producer of the 2-bit alu_op that the ALU control block consumes together with funct.
//  Supports lw, sw, R-type and beq. Every other opcode is illegal.
// PARAMETERS
//  CNT_W  32  width of the retired-instruction counter
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous active-low reset
//  opcode         in   7      IR[6:0]; stable from DECODE until next FETCH
//  mem_ready      in   1      memory handshake: the access completes in the cycle this is high
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load if ALU zero (beq)
//  ir_write       out  1      IR load
//  iord           out  1      memory address select: 0 = PC, 1 = ALUOut
//  mem_read       out  1      memory read strobe
//  mem_write      out  1      memory write strobe
//  alu_src_a      out  2      00 = PC, 01 = rs1 (A), 10 = oldPC
//  alu_src_b      out  2      00 = rs2 (B), 01 = const 4, 10 = immediate
//  alu_op         out  2      00 = add, 01 = sub (branch), 10 = use funct; 11 is never driven
//  pc_source      out  1      0 = ALU result, 1 = ALUOut (branch target)
//  reg_write      out  1      register file write enable
//  mem_to_reg     out  1      writeback select: 0 = ALUOut, 1 = MDR
//  illegal        out  1      sticky: an unsupported opcode was decoded
//  state          out  4      current state encoding (debug)
//  retired        out  CNT_W  count of completed instructions
// BEHAVIOUR
//  - Reset (rst_n low, async): state = IDLE, retired = 0, illegal = 0. All outputs are 0 in IDLE.
//  - Outputs decode combinationally from state. Exception: pc_write and ir_write in FETCH are
//    additionally ANDed with mem_ready. No state drives alu_op = 11.
//  - States and encodings:
//    IDLE=0: no strobes. Next state FETCH unconditionally.
//    FETCH=1: mem_read=1, iord=0, src_a=00, src_b=01, alu_op=00.
//      If mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay in FETCH.
//    DECODE=2: src_a=10, src_b=10, alu_op=00 (branch target into ALUOut). Dispatch on opcode:
//      0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTE; 1100011 -> BRANCH; anything else -> ILLEGAL.
//    MEMADR=3: src_a=01, src_b=10, alu_op=00. lw -> MEMREAD, sw -> MEMWRITE.
//    MEMREAD=4: mem_read=1, iord=1. If mem_ready go to MEMWB, otherwise hold.
//    MEMWB=5: reg_write=1, mem_to_reg=1. Go to FETCH.
//    MEMWRITE=6: mem_write=1, iord=1. If mem_ready go to FETCH, otherwise hold.
//    EXECUTE=7: src_a=01, src_b=00, alu_op=10. Go to ALUWB.
//    ALUWB=8: reg_write=1, mem_to_reg=0. Go to FETCH.
//    BRANCH=9: src_a=01, src_b=00, alu_op=01, pc_write_cond=1, pc_source=1. Go to FETCH.
//    ILLEGAL=10: all strobes 0, illegal=1. Held until reset.
//    Encodings 11-15 are unreachable; if entered, the next state is ILLEGAL.
//  - Cycle counts with mem_ready tied high: lw 5, sw 4, R-type 4, beq 3.
//  - retired increments by 1 on each transition into FETCH from MEMWB, MEMWRITE (with mem_ready),
//    ALUWB or BRANCH. It wraps modulo 2^CNT_W and never increments from IDLE or ILLEGAL.
//  - mem_ready is ignored in every state other than FETCH, MEMREAD and MEMWRITE.
//  - Reset asserted mid-instruction: immediate return to IDLE, all strobes drop in the same
//    cycle, no partial writeback, and retired clears to 0.
// STRUCTURE
//  - riscv_ctrl_pkg holds: opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH);
//    ALUOP_ADD, ALUOP_SUB and ALUOP_FUNCT; SRC_A_* and SRC_B_* select codes; state localparams.
//  - Sub-module main_control_outputs: pure state-to-strobe decoder. The FSM next-state logic,
//    the counter and the illegal flag stay in this module.
// TESTING
//  1. Reset, then release with mem_ready=1 -> IDLE for 1 cycle, then FETCH with mem_read=1,
//     pc_write=1, ir_write=1.
//  2. lw (0000011) with mem_ready=1 -> states 1,2,3,4,5,1; MEMWB shows reg_write=1 and
//     mem_to_reg=1; retired 0 -> 1.
//  3. R-type (0110011) -> EXECUTE with alu_op=10, then ALUWB with reg_write=1.
//     beq (1100011) -> BRANCH with alu_op=01 and pc_write_cond=1. After both, retired = 2.
//  4. sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write held high for 4 cycles,
//     retired increments only on the ready cycle.
//     FETCH stall: pc_write and ir_write stay 0 until mem_ready.
//  5. opcode 1111111 in DECODE -> ILLEGAL, illegal=1 and held, all strobes 0, retired frozen.
//     Reset clears illegal.
//  6. Drop rst_n during MEMREAD -> state=0 and all strobes 0 asynchronously; retired=0;
//     a clean lw sequence follows after release.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V main control: opcodes, ALU op codes,
// ALU operand selects and FSM state encodings.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ILLEGAL  = 4'd10
    } state_t;

endpackage

// File: rtl/multicycle_main_control_outputs.sv
// Pure state-to-strobe decoder for the multi-cycle main control.
// Only FETCH looks at mem_ready, gating the PC and IR loads.
module main_control_outputs
    import riscv_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       ir_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       pc_source_o,
    output logic       reg_write_o,
    output logic       mem_to_reg_o
);

    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        ir_write_o      = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        alu_src_a_o     = SRC_A_PC;
        alu_src_b_o     = SRC_B_RS2;
        alu_op_o        = ALUOP_ADD;
        pc_source_o     = 1'b0;
        reg_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        case (state_i)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_a_o = SRC_A_PC;
                alu_src_b_o = SRC_B_FOUR;
                pc_write_o  = mem_ready_i;
                ir_write_o  = mem_ready_i;
            end
            // Branch target is precomputed here so BRANCH only has to compare.
            S_DECODE: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
            end
            S_MEMADR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
            end
            S_MEMREAD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_RS2;
                alu_op_o    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = SRC_A_RS1;
                alu_src_b_o     = SRC_B_RS2;
                alu_op_o        = ALUOP_SUB;
                pc_write_cond_o = 1'b1;
                pc_source_o     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for the RISC-V core (lw, sw, R-type, beq).
// Owns next-state logic, the sticky illegal flag and the retired-instruction counter.
module multicycle_main_control
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic             ir_write_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             pc_source_o,
    output logic             reg_write_o,
    output logic             mem_to_reg_o,
    output logic             illegal_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired_o
);

    state_t           state_q, state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTE;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (opcode_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_ILLEGAL;
        endcase
    end

    // An instruction retires on the edge that takes it back to FETCH.
    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
            if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    main_control_outputs u_outputs (
        .state_i         (state_q),
        .mem_ready_i     (mem_ready_i),
        .pc_write_o      (pc_write_o),
        .pc_write_cond_o (pc_write_cond_o),
        .ir_write_o      (ir_write_o),
        .iord_o          (iord_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .alu_op_o        (alu_op_o),
        .pc_source_o     (pc_source_o),
        .reg_write_o     (reg_write_o),
        .mem_to_reg_o    (mem_to_reg_o)
    );

    assign illegal_o = illegal_q;
    assign state_o   = state_q;
    assign retired_o = retired_q;

endmodule
